// File: rtl/next_pc_unit_pkg.sv
// Shared pipeline definitions for the fetch-address logic: default PC width,
// sequential increment and the next-PC FSM encoding.
package next_pc_unit_pkg;

  // Default program-counter width; modules expose it as their NB_PC parameter.
  localparam int NB_PC_DEFAULT = 32;
  localparam int PC_INC        = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_ERROR  = 2'b10
  } pc_state_e;

endpackage

// File: rtl/next_pc_unit_pc_target_mux.sv
// Priority selection of the next fetch target (branch > jr > jump > sequential)
// plus redirect and misalignment flags. Purely combinational.
module pc_target_mux
  import next_pc_unit_pkg::*;
#(
  parameter int NB_PC = NB_PC_DEFAULT
) (
  input  logic             i_branch_taken,
  input  logic [NB_PC-1:0] i_branch_addr,
  input  logic             i_jr,
  input  logic [NB_PC-1:0] i_jr_addr,
  input  logic             i_jump,
  input  logic [NB_PC-1:0] i_jump_addr,
  input  logic [NB_PC-1:0] i_pc_plus_4,
  output logic [NB_PC-1:0] o_target,
  output logic             o_redirect,
  output logic             o_misaligned
);

  always_comb begin
    o_target = i_pc_plus_4;
    if (i_branch_taken) begin
      o_target = i_branch_addr;
    end else if (i_jr) begin
      o_target = i_jr_addr;
    end else if (i_jump) begin
      o_target = i_jump_addr;
    end
  end

  assign o_redirect = i_branch_taken | i_jr | i_jump;

  // Only a redirect target can be misaligned; the sequential path stays aligned.
  assign o_misaligned = o_redirect & (o_target[1:0] != 2'b00);

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter register and RUN/HALTED/ERROR control FSM; target selection
// lives in pc_target_mux.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int               NB_PC    = NB_PC_DEFAULT,
  parameter logic [NB_PC-1:0] RESET_PC = '0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [NB_PC-1:0] i_branch_addr,
  input  logic             i_jr,
  input  logic [NB_PC-1:0] i_jr_addr,
  input  logic             i_jump,
  input  logic [NB_PC-1:0] i_jump_addr,
  input  logic             i_halt,
  output logic [NB_PC-1:0] o_pc,
  output logic [NB_PC-1:0] o_pc_plus_4,
  output logic             o_flush,
  output logic             o_halted,
  output logic             o_error
);

  pc_state_e        state_reg, state_next;
  logic [NB_PC-1:0] pc_reg, pc_next;
  logic             flush_reg, flush_next;

  logic [NB_PC-1:0] target;
  logic             redirect;
  logic             misaligned;

  assign o_pc_plus_4 = pc_reg + NB_PC'(PC_INC);

  pc_target_mux #(
    .NB_PC (NB_PC)
  ) u_pc_target_mux (
    .i_branch_taken (i_branch_taken),
    .i_branch_addr  (i_branch_addr),
    .i_jr           (i_jr),
    .i_jr_addr      (i_jr_addr),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .i_pc_plus_4    (o_pc_plus_4),
    .o_target       (target),
    .o_redirect     (redirect),
    .o_misaligned   (misaligned)
  );

  // Disabled cycles freeze everything, including a pending flush pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= ST_RUN;
      pc_reg    <= RESET_PC;
      flush_reg <= 1'b0;
    end else if (i_enable) begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      flush_reg <= flush_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flush_next = 1'b0;
    case (state_reg)
      ST_RUN: begin
        // A redirect overrides both stall and halt.
        if (redirect) begin
          if (misaligned) begin
            state_next = ST_ERROR;
          end else begin
            pc_next    = target;
            flush_next = 1'b1;
          end
        end else if (i_halt) begin
          state_next = ST_HALTED;
        end else if (!i_stall) begin
          pc_next = o_pc_plus_4;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_pc     = pc_reg;
  assign o_flush  = flush_reg;
  assign o_halted = (state_reg == ST_HALTED);
  assign o_error  = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit with hand-computed expectations.
module tb_next_pc_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_addr;
  logic        i_jr;
  logic [31:0] i_jr_addr;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic        i_halt;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus_4;
  logic        o_flush;
  logic        o_halted;
  logic        o_error;

  int checks = 0;
  int errors = 0;

  next_pc_unit #(
    .NB_PC    (32),
    .RESET_PC (32'h0)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_branch_addr  (i_branch_addr),
    .i_jr           (i_jr),
    .i_jr_addr      (i_jr_addr),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .i_halt         (i_halt),
    .o_pc           (o_pc),
    .o_pc_plus_4    (o_pc_plus_4),
    .o_flush        (o_flush),
    .o_halted       (o_halted),
    .o_error        (o_error)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end else begin
      $display("pass %s: 0x%08h", tag, observed);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_redirects();
    i_branch_taken = 1'b0;
    i_jr           = 1'b0;
    i_jump         = 1'b0;
    i_halt         = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic flush,
                             input logic halted, input logic err);
    check({tag, ".pc"},     o_pc,            pc);
    check({tag, ".flush"},  32'(o_flush),    32'(flush));
    check({tag, ".halted"}, 32'(o_halted),   32'(halted));
    check({tag, ".error"},  32'(o_error),    32'(err));
  endtask

  initial begin
    i_reset        = 1'b1;
    i_enable       = 1'b0;
    i_stall        = 1'b0;
    i_branch_addr  = 32'h0;
    i_jr_addr      = 32'h0;
    i_jump_addr    = 32'h0;
    clear_redirects();

    // Reset applies even with i_enable low.
    step();
    step();
    check_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.pc4", o_pc_plus_4, 32'h4);

    // Sequential fetch.
    i_reset  = 1'b0;
    i_enable = 1'b1;
    step(); check_state("seq1", 32'h4, 1'b0, 1'b0, 1'b0);
    step(); check_state("seq2", 32'h8, 1'b0, 1'b0, 1'b0);
    step(); check_state("seq3", 32'hC, 1'b0, 1'b0, 1'b0);
    step(); check("seq4.pc", o_pc, 32'h10);

    // Jump from 0x10.
    i_jump = 1'b1; i_jump_addr = 32'h0000_0400;
    step();
    check_state("jump", 32'h400, 1'b1, 1'b0, 1'b0);
    check("jump.pc4", o_pc_plus_4, 32'h404);
    clear_redirects();
    step(); check_state("jump_after", 32'h404, 1'b0, 1'b0, 1'b0);

    // Stall without redirect holds.
    i_stall = 1'b1;
    step(); check_state("stall", 32'h404, 1'b0, 1'b0, 1'b0);

    // All redirects together under stall: branch wins.
    i_branch_taken = 1'b1; i_branch_addr = 32'h80;
    i_jr           = 1'b1; i_jr_addr     = 32'h90;
    i_jump         = 1'b1; i_jump_addr   = 32'hA0;
    step(); check_state("prio_br", 32'h80, 1'b1, 1'b0, 1'b0);
    clear_redirects();
    step(); check_state("prio_hold", 32'h80, 1'b0, 1'b0, 1'b0);

    // jr beats jump.
    i_stall = 1'b0;
    i_jr = 1'b1; i_jump = 1'b1;
    step(); check_state("prio_jr", 32'h90, 1'b1, 1'b0, 1'b0);
    clear_redirects();

    // Get to 0x20, then halt with stall asserted.
    i_branch_taken = 1'b1; i_branch_addr = 32'h20;
    step(); check("to20.pc", o_pc, 32'h20);
    clear_redirects();
    i_halt = 1'b1; i_stall = 1'b1;
    step(); check_state("halt", 32'h20, 1'b0, 1'b1, 1'b0);

    // HALTED ignores everything but reset.
    for (int i = 0; i < 10; i++) begin
      i_halt         = i[0];
      i_stall        = i[1];
      i_branch_taken = ~i[0];
      i_jr           = i[0];
      i_jump         = 1'b1;
      i_jr_addr      = 32'h100;
      i_jump_addr    = 32'h300;
      i_enable       = (i != 3);
      step();
      check_state("halted_hold", 32'h20, 1'b0, 1'b1, 1'b0);
    end
    clear_redirects();
    i_stall = 1'b0; i_enable = 1'b1;
    i_reset = 1'b1;
    step(); check_state("halt_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;

    // Misaligned jr -> ERROR, PC unchanged.
    step(); check("pre_err.pc", o_pc, 32'h4);
    i_jr = 1'b1; i_jr_addr = 32'h102;
    step(); check_state("err", 32'h4, 1'b0, 1'b0, 1'b1);
    clear_redirects();
    i_branch_taken = 1'b1; i_branch_addr = 32'h40;
    step(); check_state("err_hold", 32'h4, 1'b0, 1'b0, 1'b1);
    clear_redirects();
    step(); check_state("err_hold2", 32'h4, 1'b0, 1'b0, 1'b1);
    i_reset = 1'b1;
    step(); check_state("err_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;

    // Redirect squashes a simultaneous halt.
    i_halt = 1'b1; i_branch_taken = 1'b1; i_branch_addr = 32'h200;
    step(); check_state("halt_squash", 32'h200, 1'b1, 1'b0, 1'b0);
    clear_redirects();

    // Disabled: everything frozen, flush pulse held but not repeated.
    i_enable = 1'b0; i_jump = 1'b1; i_jump_addr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      step(); check_state("frozen", 32'h200, 1'b1, 1'b0, 1'b0);
    end
    i_jump = 1'b0; i_enable = 1'b1;
    step(); check_state("unfreeze", 32'h204, 1'b0, 1'b0, 1'b0);

    // Wrap at the top of the address space.
    i_branch_taken = 1'b1; i_branch_addr = 32'hFFFF_FFFC;
    step(); check_state("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    check("top.pc4", o_pc_plus_4, 32'h0);
    clear_redirects();
    step(); check_state("wrap", 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset on top of a redirect discards it.
    i_jump = 1'b1; i_jump_addr = 32'h500; i_reset = 1'b1;
    step(); check_state("reset_redir", 32'h0, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0; clear_redirects();
    step(); check("post_reset.pc", o_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
